// File: rtl/core_wb_load_queue.sv
// core_wb_load_queue: in-order load queue that pairs memory responses with issued loads and formats writeback data.
module core_wb_load_queue #(
  parameter int XLEN = 64,
  parameter int DEPTH = 4,
  parameter int REG_ADDR_W = 5,
  localparam int OW = $clog2(XLEN / 8),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [REG_ADDR_W-1:0] req_rd,
  input  logic [1:0]            req_size,
  input  logic                  req_sext,
  input  logic [OW-1:0]         req_offset,
  input  logic                  rsp_valid,
  input  logic                  rsp_err,
  input  logic [XLEN-1:0]       rsp_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_err,
  input  logic                  flush,
  output logic                  spurious,
  output logic [PW:0]           pending,
  output logic                  empty
);
  typedef enum logic [1:0] {FREE, WAIT, DONE} state_t;
  state_t                st     [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [1:0]            size_q [DEPTH];
  logic                  sext_q [DEPTH];
  logic [OW-1:0]         off_q  [DEPTH];
  logic [XLEN-1:0]       raw_q  [DEPTH];
  logic                  err_q  [DEPTH];
  logic [PW-1:0] head, tail, rptr;
  logic [PW:0] cnt, disc, nwait;
  logic [PW+1:0] disc_sum;
  logic spur_q, push, pop, rmatch, consumed, top;
  logic [1:0] sz;
  logic [6:0] nb;
  logic [XLEN-1:0] sh, mask, ext;
  assign req_ready = !g_reset && cnt < (PW+1)'(DEPTH) && !flush;
  assign push = req_valid && req_ready;
  assign wb_valid = !g_reset && !flush && st[head] == DONE;
  assign pop = wb_valid && wb_ready;
  assign consumed = rsp_valid && disc != '0;
  // rptr always sits on the oldest WAIT entry when one exists
  assign rmatch = rsp_valid && disc == '0 && st[rptr] == WAIT;
  always_comb begin
    nwait = '0;
    for (int i = 0; i < DEPTH; i++)
      nwait = nwait + (PW+1)'(st[i] == WAIT);
    disc_sum = (PW+2)'(disc) - (PW+2)'(consumed) + (PW+2)'(nwait) - (PW+2)'(rmatch);
  end
  always_comb begin
    sz = (XLEN == 32 && size_q[head] == 2'd3) ? 2'd2 : size_q[head];
    nb = 7'd8 << sz;
    sh = raw_q[head] >> {off_q[head], 3'b000};
    mask = ~({XLEN{1'b1}} << nb);
    top = |(sh & (XLEN'(1) << (nb - 7'd1)));
    ext = (sh & mask) | ({XLEN{sext_q[head] & top}} & ~mask);
  end
  assign wb_data = (g_reset || err_q[head]) ? '0 : (sz == 2'd3) ? raw_q[head] : ext;
  assign wb_rd = g_reset ? '0 : rd_q[head];
  assign wb_err = !g_reset && err_q[head];
  assign pending = g_reset ? '0 : cnt;
  assign empty = pending == '0;
  assign spurious = spur_q && !g_reset;
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
      head <= '0;
      tail <= '0;
      rptr <= '0;
      cnt <= '0;
      disc <= '0;
      spur_q <= 1'b0;
    end else begin
      spur_q <= rsp_valid && disc == '0 && !rmatch;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
        head <= '0;
        tail <= '0;
        rptr <= '0;
        cnt <= '0;
        disc <= (disc_sum > (PW+2)'(DEPTH)) ? (PW+1)'(DEPTH) : disc_sum[PW:0];
      end else begin
        if (push) begin
          st[tail] <= WAIT;
          rd_q[tail] <= req_rd;
          size_q[tail] <= req_size;
          sext_q[tail] <= req_sext;
          off_q[tail] <= req_offset;
          tail <= tail + 1'b1;
        end
        if (rmatch) begin
          st[rptr] <= DONE;
          raw_q[rptr] <= rsp_rdata;
          err_q[rptr] <= rsp_err;
          rptr <= rptr + 1'b1;
        end
        if (pop) begin
          st[head] <= FREE;
          head <= head + 1'b1;
        end
        if (consumed) disc <= disc - (PW+1)'(1);
        cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end
endmodule
